dmem_wbuf: RTL and testbench

DMEM_WBUF -- requirements
Module: dmem_wbuf

---
 rtl/dmem_pkg.sv | 13 +
 rtl/wbuf_fifo.sv | 57 +++++
 rtl/dmem_wbuf.sv | 88 ++++++++
 tb/tb_dmem_wbuf.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and the write-buffer entry layout for the data memory.
// The entry address field is sized for the default array; ADDR_W must not exceed it.
package dmem_pkg;

  localparam int DMEM_ADDR_W   = 14;
  localparam int DMEM_WB_DEPTH = 4;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [31:0]            data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular write buffer for posted stores: push at tail, pop at head,
// plus a parallel view of every slot so the owner can forward to loads.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter  int DEPTH = DMEM_WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wbuf_entry_t      i_push_entry,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output logic [PTR_W-1:0] o_head,
  output wbuf_entry_t      o_head_entry,
  output wbuf_entry_t      o_entries [DEPTH]
);

  wbuf_entry_t      r_ent [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);

  // Slot contents need no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_ent[r_tail] <= i_push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop_ok)  r_head <= r_head + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head       = r_head;
  assign o_head_entry = r_ent[r_head];
  assign o_entries    = r_ent;

endmodule

// File: rtl/dmem_wbuf.sv
// Single-port data memory fronted by a posted-store write buffer; loads own the
// array port and forward from the youngest matching pending store.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memDataAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWriteEnable,
  input  logic        memReadEnable,
  output logic [31:0] memReadData,
  output logic        stall
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (ADDR_W > DMEM_ADDR_W) begin : g_addr_w_check
    $error("dmem_wbuf: ADDR_W exceeds the entry address field width");
  end

  logic [31:0]            r_mem [2**ADDR_W];
  logic [ADDR_W-1:0]      w_word_idx;
  logic [DMEM_ADDR_W-1:0] w_word_idx_ext;
  logic                   w_push;
  logic                   w_pop;
  wbuf_entry_t            w_push_entry;
  wbuf_entry_t            w_head_entry;
  wbuf_entry_t            w_entries [WB_DEPTH];
  logic [CNT_W-1:0]       w_count;
  logic [PTR_W-1:0]       w_head;
  logic [PTR_W-1:0]       w_slot;
  logic                   w_fwd_hit;
  logic [31:0]            w_fwd_data;
  logic                   w_unused_addr_bits;

  assign w_word_idx         = memDataAddress[ADDR_W+1:2];
  assign w_word_idx_ext     = DMEM_ADDR_W'(w_word_idx);
  assign w_unused_addr_bits = ^{memDataAddress[31:ADDR_W+2], memDataAddress[1:0]};

  assign stall  = (w_count == CNT_W'(WB_DEPTH));
  assign w_push = !reset && memWriteEnable && !stall;
  // A load holds the array port, so draining waits for a cycle without one.
  assign w_pop  = !reset && (w_count != '0) && !memReadEnable;

  assign w_push_entry.addr = w_word_idx_ext;
  assign w_push_entry.data = memWriteData;

  wbuf_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head       (w_head),
    .o_head_entry (w_head_entry),
    .o_entries    (w_entries)
  );

  always_ff @(posedge clk) begin
    if (w_pop) r_mem[w_head_entry.addr[ADDR_W-1:0]] <= w_head_entry.data;
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_slot     = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_slot = w_head + PTR_W'(i);
      if ((CNT_W'(i) < w_count) && (w_entries[w_slot].addr == w_word_idx_ext)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entries[w_slot].data;
      end
    end
  end

  always_comb begin
    memReadData = '0;
    if (memReadEnable) memReadData = w_fwd_hit ? w_fwd_data : r_mem[w_word_idx];
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: forwarding, full-buffer stall, ordering,
// same-cycle load/store, mid-run reset, and a random stream against a flat model.
module tb_dmem_wbuf;

  logic        clk;
  logic        reset;
  logic [31:0] memDataAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic        memReadEnable;
  logic [31:0] memReadData;
  logic        stall;

  int checks = 0;
  int errors = 0;

  dmem_wbuf dut (
    .clk            (clk),
    .reset          (reset),
    .memDataAddress (memDataAddress),
    .memWriteData   (memWriteData),
    .memWriteEnable (memWriteEnable),
    .memReadEnable  (memReadEnable),
    .memReadData    (memReadData),
    .stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    memWriteEnable = we;
    memReadEnable  = re;
    memDataAddress = a;
    memWriteData   = d;
    #2;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    checks++;
    if (dut.w_count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", dut.w_count);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_forward();
    drive(1'b1, 1'b0, 32'h40, 32'h11);
    step();
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    checks++;
    if (memReadData !== 32'h11) begin
      errors++; $display("FAIL fwd_data: got %h expected 00000011", memReadData);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL fwd_stall: got %b expected 0", stall);
    end
    step();
    drive(1'b0, 1'b0, 32'h40, 32'h0);
    checks++;
    if (memReadData !== 32'h0) begin
      errors++; $display("FAIL rd_disabled_zero: got %h expected 00000000", memReadData);
    end
    step();
    drain_all();
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    checks++;
    if (memReadData !== 32'h11) begin
      errors++; $display("FAIL fwd_after_drain: got %h expected 00000011", memReadData);
    end
    step();
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(i * 4), 32'hD0 + 32'(i));
      step();
      if (i < 3) begin
        drive(1'b0, 1'b1, 32'h100, 32'h0);
        if (i == 2) begin
          checks++;
          if (stall !== 1'b0) begin
            errors++; $display("FAIL stall_at_3: got %b expected 0", stall);
          end
        end
        step();
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL stall_at_full: got %b expected 1", stall);
    end
    step();
    drive(1'b1, 1'b0, 32'h14, 32'hD4);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_one_cycle: got %b expected 0", stall);
    end
    step();
    drain_all();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 32'h0);
      checks++;
      if (memReadData !== 32'hD0 + 32'(i)) begin
        errors++; $display("FAIL full_drain_word%0d: got %h expected %h", i, memReadData, 32'hD0 + 32'(i));
      end
      step();
    end
    drive(1'b0, 1'b1, 32'h14, 32'h0);
    checks++;
    if (memReadData !== 32'hD4) begin
      errors++; $display("FAIL store_after_stall: got %h expected 000000d4", memReadData);
    end
    step();
  endtask

  task automatic test_same_word();
    drive(1'b1, 1'b1, 32'h80, 32'hA);
    step();
    drive(1'b1, 1'b1, 32'h80, 32'hB);
    step();
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    checks++;
    if (memReadData !== 32'hB) begin
      errors++; $display("FAIL youngest_fwd: got %h expected 0000000b", memReadData);
    end
    step();
    drain_all();
    checks++;
    if (dut.r_mem[32] !== 32'hB) begin
      errors++; $display("FAIL array_final: got %h expected 0000000b", dut.r_mem[32]);
    end
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    checks++;
    if (memReadData !== 32'hB) begin
      errors++; $display("FAIL same_word_load: got %h expected 0000000b", memReadData);
    end
    step();
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 1'b0, 32'h10, 32'h5);
    step();
    drain_all();
    drive(1'b1, 1'b1, 32'h10, 32'h9);
    checks++;
    if (memReadData !== 32'h5) begin
      errors++; $display("FAIL same_cycle_old: got %h expected 00000005", memReadData);
    end
    step();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    checks++;
    if (memReadData !== 32'h9) begin
      errors++; $display("FAIL same_cycle_next: got %h expected 00000009", memReadData);
    end
    step();
    drain_all();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    checks++;
    if (memReadData !== 32'h9) begin
      errors++; $display("FAIL same_cycle_drained: got %h expected 00000009", memReadData);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 32'h00, 32'hEE0);
    step();
    drive(1'b1, 1'b1, 32'h04, 32'hEE1);
    step();
    drive(1'b1, 1'b1, 32'h80, 32'hEE2);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (dut.w_count !== 3'd0) begin
      errors++; $display("FAIL mid_reset_count: got %0d expected 0", dut.w_count);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset_stall: got %b expected 0", stall);
    end
    step();
    drain_all();
    drive(1'b0, 1'b1, 32'h00, 32'h0);
    checks++;
    if (memReadData !== 32'hD0) begin
      errors++; $display("FAIL mid_reset_w0: got %h expected 000000d0", memReadData);
    end
    step();
    drive(1'b0, 1'b1, 32'h04, 32'h0);
    checks++;
    if (memReadData !== 32'hD1) begin
      errors++; $display("FAIL mid_reset_w1: got %h expected 000000d1", memReadData);
    end
    step();
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    checks++;
    if (memReadData !== 32'hB) begin
      errors++; $display("FAIL mid_reset_w32: got %h expected 0000000b", memReadData);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] model [8];
    logic [1:0]  prev_head;
    int          wraps;
    int          op;
    logic [2:0]  widx;
    logic [2:0]  ridx;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      model[i] = 32'h1000 + 32'(i);
      drive(1'b1, 1'b0, 32'(i * 4), model[i]);
      step();
    end
    drain_all();
    for (int n = 0; n < 400; n++) begin
      prev_head = dut.u_fifo.r_head;
      op    = int'($urandom_range(0, 3));
      widx  = 3'($urandom_range(0, 7));
      ridx  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      we    = (op == 0 || op == 2) && !stall;
      re    = (op == 1 || op == 2) && !stall;
      memWriteEnable = we;
      memReadEnable  = re;
      memWriteData   = wdata;
      memDataAddress = we ? {27'h0, widx, 2'b00} : {27'h0, ridx, 2'b00};
      #2;
      if (re) begin
        checks++;
        if (memReadData !== model[we ? widx : ridx]) begin
          errors++; $display("FAIL rand_load n=%0d: got %h expected %h", n, memReadData, model[we ? widx : ridx]);
        end
      end
      if (we) model[widx] = wdata;
      step();
      if (dut.u_fifo.r_head < prev_head) wraps++;
    end
    drain_all();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 32'h0);
      checks++;
      if (memReadData !== model[i]) begin
        errors++; $display("FAIL rand_final_w%0d: got %h expected %h", i, memReadData, model[i]);
      end
      step();
    end
    checks++;
    if (wraps < 3) begin
      errors++; $display("FAIL rand_wraps: got %0d expected at least 3", wraps);
    end
  endtask

  initial begin
    reset          = 1'b1;
    memWriteEnable = 1'b0;
    memReadEnable  = 1'b0;
    memDataAddress = 32'h0;
    memWriteData   = 32'h0;
    void'($urandom(32'h5eed));
    test_reset();
    test_forward();
    test_full_stall();
    test_same_word();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
